// File: rtl/lfsr_rng_bank_if.sv
// Bus bundle for lfsr_rng_bank.
//   master : drives seed, load, en, prob; observes dataOut, valid, sample, sampleValid
//   slave  : the RNG bank itself
// Channel c of any NCH*W bus occupies bits [c*W +: W].
interface lfsr_rng_bank_if #(
  parameter int W   = 8,
  parameter int NCH = 4
);
  logic [NCH*W-1:0] seed;
  logic             load;
  logic             en;
  logic [NCH*W-1:0] prob;
  logic [NCH*W-1:0] dataOut;
  logic             valid;
  logic [NCH-1:0]   sample;
  logic             sampleValid;

  modport master (
    output seed, load, en, prob,
    input  dataOut, valid, sample, sampleValid
  );

  modport slave (
    input  seed, load, en, prob,
    output dataOut, valid, sample, sampleValid
  );
endinterface

// File: rtl/lfsr_rng_bank.sv
// lfsr_rng_bank: NCH independent Fibonacci LFSRs with lock-up protection,
// a programmable warm-up after reset/reseed, and lock-step stepping on en.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; reloads seeds and restarts warm-up
//   bus   : lfsr_rng_bank_if.slave (seed, load, en, prob in;
//           dataOut, valid, sample, sampleValid out)
//
// Optional feature macro: RNG_BERNOULLI_EN
//   defined   -> per-channel comparator sample[c] = dataOut[c] < prob[c],
//                registered on each honoured step, strobed by sampleValid
//   undefined -> sample/sampleValid tied low, prob ignored
//
// state | meaning
// WARM  | free-running warm-up, cnt counts completed steps, valid low
// RUN   | output valid, channels step only on en
module lfsr_rng_bank #(
  parameter int             W      = 8,
  parameter int             NCH    = 4,
  parameter logic [W-1:0]   TAPS   = 8'hB8,
  parameter int             WARMUP = 4
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_rng_bank_if.slave    bus
);

  typedef enum logic {WARM, RUN} state_t;

  // With WARMUP == 0 the bank never enters WARM, so WARM_LAST is unused.
  localparam state_t     START_STATE = (WARMUP == 0) ? RUN : WARM;
  localparam logic [7:0] WARM_LAST   = 8'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             step;
  logic [NCH*W-1:0] data;

  // The (r == 0) term forces an all-zero register to step to 1.
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] r);
    logic fb;
    fb = (^(r & TAPS)) ^ (r == '0);
    return {r[W-2:0], fb};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= START_STATE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    if (bus.load) begin
      state_nxt = START_STATE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        WARM: begin
          step    = 1'b1;
          cnt_nxt = cnt + 8'd1;
          if (cnt == WARM_LAST) state_nxt = RUN;
        end
        RUN: step = bus.en;
        default: state_nxt = START_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      data <= bus.seed;
    end else if (step) begin
      for (int c = 0; c < NCH; c++) begin
        data[c*W +: W] <= lfsr_step(data[c*W +: W]);
      end
    end
  end

  assign bus.dataOut = data;
  assign bus.valid   = (state == RUN);

`ifdef RNG_BERNOULLI_EN
  logic [NCH-1:0] cmp;
  logic [NCH-1:0] sample_q;
  logic           sample_valid_q;

  // Compare uses the pre-step word, i.e. the value visible on dataOut.
  always_comb begin
    cmp = '0;
    for (int c = 0; c < NCH; c++) begin
      cmp[c] = data[c*W +: W] < bus.prob[c*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else if ((state == RUN) && bus.en) begin
      sample_q       <= cmp;
      sample_valid_q <= 1'b1;
    end else begin
      sample_valid_q <= 1'b0;
    end
  end

  assign bus.sample      = sample_q;
  assign bus.sampleValid = sample_valid_q;
`else
  assign bus.sample      = '0;
  assign bus.sampleValid = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rng_bank.sv
// Testbench for lfsr_rng_bank: two instances (WARMUP=4 and WARMUP=0) share
// stimulus; a reference model predicts every post-edge output, a monitor
// compares at the falling edge, and directed checks cover the key scenarios.
module tb_lfsr_rng_bank;
  localparam int           W    = 8;
  localparam int           NCH  = 2;
  localparam logic [W-1:0] TAPS = 8'hB8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_v, load_v, en_v;
  logic [NCH*W-1:0] seed_v, prob_v;

  lfsr_rng_bank_if #(.W(W), .NCH(NCH)) bus4 ();
  lfsr_rng_bank_if #(.W(W), .NCH(NCH)) bus0 ();

  assign bus4.seed = seed_v;  assign bus0.seed = seed_v;
  assign bus4.prob = prob_v;  assign bus0.prob = prob_v;
  assign bus4.load = load_v;  assign bus0.load = load_v;
  assign bus4.en   = en_v;    assign bus0.en   = en_v;

  lfsr_rng_bank #(.W(W), .NCH(NCH), .TAPS(TAPS), .WARMUP(4)) u_dut4 (
    .clk(clk), .reset(rst_v), .bus(bus4));
  lfsr_rng_bank #(.W(W), .NCH(NCH), .TAPS(TAPS), .WARMUP(0)) u_dut0 (
    .clk(clk), .reset(rst_v), .bus(bus0));

  typedef struct packed {
    logic [1:0][NCH*W-1:0] d;
    logic [1:0]            v;
    logic [1:0][NCH-1:0]   s;
    logic [1:0]            sv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, index 0 = WARMUP 4 instance, 1 = WARMUP 0 instance.
  logic [W-1:0]   m_data [2][NCH];
  int             m_left [2];
  logic [NCH-1:0] m_samp [2];
  logic           m_sv   [2];
  int             wu     [2] = '{4, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Parity of tapped bits plus one extra for the zero state, shifted in at the bottom.
  function automatic logic [W-1:0] ref_next(input logic [W-1:0] r);
    int ones = 0;
    int v;
    for (int i = 0; i < W; i++)
      if ((((int'(TAPS)) >> i) & 1) == 1 && (((int'(r)) >> i) & 1) == 1) ones++;
    if (r == 0) ones++;
    v = (int'(r) * 2 + (ones % 2)) % (1 << W);
    return v[W-1:0];
  endfunction

  task automatic model_step(input logic rst, input logic ld, input logic e);
    exp_t ex;
    for (int k = 0; k < 2; k++) begin
      if (rst || ld) begin
        for (int c = 0; c < NCH; c++) m_data[k][c] = seed_v[c*W +: W];
        m_left[k] = wu[k];
        m_samp[k] = '0;
        m_sv[k]   = 1'b0;
      end else if (m_left[k] > 0) begin
        for (int c = 0; c < NCH; c++) m_data[k][c] = ref_next(m_data[k][c]);
        m_left[k]--;
        m_sv[k] = 1'b0;
      end else if (e) begin
`ifdef RNG_BERNOULLI_EN
        for (int c = 0; c < NCH; c++) m_samp[k][c] = (m_data[k][c] < prob_v[c*W +: W]);
        m_sv[k] = 1'b1;
`else
        m_sv[k] = 1'b0;
`endif
        for (int c = 0; c < NCH; c++) m_data[k][c] = ref_next(m_data[k][c]);
      end else begin
        m_sv[k] = 1'b0;
      end
      for (int c = 0; c < NCH; c++) ex.d[k][c*W +: W] = m_data[k][c];
      ex.v[k]  = (m_left[k] == 0);
      ex.s[k]  = m_samp[k];
      ex.sv[k] = m_sv[k];
    end
    exp_q.push_back(ex);
  endtask

  // One clock: drive inputs, predict, let the edge happen, settle.
  task automatic cyc(input logic rst, input logic ld, input logic e);
    rst_v  = rst;
    load_v = ld;
    en_v   = e;
    model_step(rst, ld, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] dut_ch(input int k, input int c);
    logic [NCH*W-1:0] d;
    d = (k == 0) ? bus4.dataOut : bus0.dataOut;
    return d[c*W +: W];
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("mon_data4",   bus4.dataOut,     e.d[0]);
      check("mon_valid4",  bus4.valid,       e.v[0]);
      check("mon_sample4", bus4.sample,      e.s[0]);
      check("mon_sv4",     bus4.sampleValid, e.sv[0]);
      check("mon_data0",   bus0.dataOut,     e.d[1]);
      check("mon_valid0",  bus0.valid,       e.v[1]);
      check("mon_sample0", bus0.sample,      e.s[1]);
      check("mon_sv0",     bus0.sampleValid, e.sv[1]);
    end
  end

  initial begin
    int             first_ret;
    logic           seen_zero;
    logic [W-1:0]   exp_w [NCH];
    logic           rr, ll;

    rst_v  = 1'b1;
    load_v = 1'b0;
    en_v   = 1'b0;
    seed_v = {8'h00, 8'h01};
    prob_v = {8'h05, 8'h80};

    // Reset and warm-up
    cyc(1'b1, 1'b0, 1'b0);
    check("rst_ch0",     dut_ch(0, 0), 8'h01);
    check("rst_ch1",     dut_ch(0, 1), 8'h00);
    check("rst_valid",   bus4.valid, 1'b0);
    check("rst_valid_wu0", bus0.valid, 1'b1);
    check("rst_sample",  bus4.sample, 2'b00);
    check("rst_sv",      bus4.sampleValid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("warm_valid", bus4.valid, (i == 3));
    end
    check("warm_ch0", dut_ch(0, 0), 8'h11);
    check("warm_ch1", dut_ch(0, 1), 8'h08);

    // Step and hold, with the Bernoulli sample on the first step
    cyc(1'b0, 1'b0, 1'b1);
    check("step1_ch0", dut_ch(0, 0), 8'h23);
`ifdef RNG_BERNOULLI_EN
    check("bern_sample", bus4.sample, 2'b01);
    check("bern_sv",     bus4.sampleValid, 1'b1);
`else
    check("bern_sample_off", bus4.sample, 2'b00);
    check("bern_sv_off",     bus4.sampleValid, 1'b0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    check("hold1_ch0", dut_ch(0, 0), 8'h23);
    check("sv_pulse_end", bus4.sampleValid, 1'b0);
`ifdef RNG_BERNOULLI_EN
    check("sample_held", bus4.sample, 2'b01);
`else
    check("sample_off_held", bus4.sample, 2'b00);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    check("hold2_ch0", dut_ch(0, 0), 8'h23);
    cyc(1'b0, 1'b0, 1'b1);
    check("step2_ch0", dut_ch(0, 0), 8'h47);
    check("run_valid", bus4.valid, 1'b1);

    // Period on the WARMUP=0 instance
    cyc(1'b1, 1'b0, 1'b1);
    check("p_start", dut_ch(1, 0), 8'h01);
    first_ret = 0;
    seen_zero = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (dut_ch(1, 0) == 8'h00) seen_zero = 1'b1;
      if (first_ret == 0 && dut_ch(1, 0) == 8'h01) first_ret = i;
    end
    check("period", first_ret, 255);
    check("no_zero", seen_zero, 1'b0);

    // Reload with load and en together
    seed_v = {8'h3C, 8'hA5};
    cyc(1'b0, 1'b1, 1'b1);
    check("reload_data",  bus4.dataOut, 16'h3CA5);
    check("reload_valid", bus4.valid, 1'b0);
    exp_w[0] = 8'hA5;
    exp_w[1] = 8'h3C;
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < NCH; c++) exp_w[c] = ref_next(exp_w[c]);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      check("reload_warm_valid", bus4.valid, (i == 3));
    end
    check("reload_ch0", dut_ch(0, 0), exp_w[0]);
    check("reload_ch1", dut_ch(0, 1), exp_w[1]);

    // Reset mid-warm-up
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("midrst_ch0",   dut_ch(0, 0), 8'hA5);
    check("midrst_valid", bus4.valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("midrst_warm_valid", bus4.valid, (i == 3));
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom % 64) == 0;
      ll = ($urandom % 16) == 0;
      if (rr || ll) seed_v = (($urandom % 4) == 0) ? '0 : 16'($urandom);
      if (($urandom % 8) == 0) prob_v = 16'($urandom);
      cyc(rr, ll, 1'($urandom % 2));
    end
    rst_v  = 1'b0;
    load_v = 1'b0;
    en_v   = 1'b0;

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lfsr_rng_bank.md
# lfsr_rng_bank

Parametrised multi-channel pseudo-random source for the stochastic units of the RBM datapath. It holds NCH independent Fibonacci LFSRs of configurable width and tap mask, each protected against the all-zero lock-up state. After reset or a reseed it runs a programmable warm-up, then steps all channels together on demand. An optional per-channel Bernoulli comparator turns each random word into a sampled neuron bit.

## Interface
Parameters:
- `W`, default 8: LFSR width in bits, minimum 3.
- `NCH`, default 4: number of channels.
- `TAPS`, default `8'hB8`: W-bit feedback mask. Bit i set means `r[i]` is XORed into the feedback.
- `WARMUP`, default 4: number of free-running steps after reset or load before output is valid. Range 0–255.

Ports:
- `clk`, in, 1: the single clock; everything updates on the rising edge.
- `reset`, in, 1: synchronous, active-high. Loads seeds and restarts warm-up.
- `seed`, in, NCH*W: per-channel seeds; channel c is `seed[c*W +: W]`.
- `load`, in, 1: reseed pulse; samples `seed` on the edge where it is high.
- `en`, in, 1: step request, honoured only in RUN.
- `prob`, in, NCH*W: per-channel threshold, used only with the Bernoulli feature.
- `dataOut`, out, NCH*W: current LFSR states.
- `valid`, out, 1: high when `dataOut` is post-warm-up.
- `sample`, out, NCH: Bernoulli sample bits.
- `sampleValid`, out, 1: one-cycle strobe marking `sample` as updated.

## Operation
- Per-channel next state is `{r[W-2:0], fb}`, where `fb = ^(r & TAPS) ^ (r == 0)`. An all-zero state therefore steps to 1 and never sticks.
- The FSM has two states, WARM and RUN, with a counter of 8 bits.
- On reset or load: every channel takes its seed, `cnt` is set to 0, and the state becomes RUN if `WARMUP == 0`, otherwise WARM.
- In WARM, all channels step every cycle regardless of `en`, and `cnt` increments. On the edge where `cnt == WARMUP-1`, the state moves to RUN. This gives exactly WARMUP steps before the output is valid.
- In RUN, all channels step on an edge where `en` is high and hold otherwise.
- `valid` is 1 iff the state is RUN. It is a registered output with no combinational path from `en`.
- Priority is reset > load > en. `load` while `en` is high reloads the seeds and does not step. `load` mid-warm-up restarts the warm-up from 0.
- Reset in any state follows the same path as load. All NCH channels always share the same state and counter.

## Timing
- Values after a reset edge:
  - `dataOut` = `seed`.
  - `valid` = 0, or 1 if `WARMUP == 0`.
  - `sample` = 0.
  - `sampleValid` = 0.
- Load or reset to first valid output takes WARMUP cycles. `dataOut` then shows the seed advanced WARMUP steps.
- Step latency: an `en`-high edge in RUN updates `dataOut` at that edge, so the new value is visible in the following cycle.
- Period per channel equals the polynomial period. For the default TAPS this is 255, and all-zero is a transient state that is never revisited.

## Configuration
- Macro: `RNG_BERNOULLI_EN`.
- Defined: on every edge with `valid && en && !load && !reset`:
  - `sample[c]` is registered as `dataOut[c] < prob[c]`, an unsigned W-bit compare using the pre-step `dataOut`.
  - `sampleValid` is registered to 1; it is 0 on every other edge.
  - Sample latency is 1 cycle after the `en` edge.
  - `sample` holds its value between strobes and clears on reset or load.
- Not defined: `sample` and `sampleValid` are tied to 0, `prob` is ignored, and no comparator logic is generated.

## Test plan
Common setup: `W=8`, `NCH=2`, `TAPS=8'hB8`, channel 0 seed `8'h01`, channel 1 seed `8'h00`.

1. Warm-up, `WARMUP=4`: hold reset for 1 edge, then release. `valid` must be 0 for 4 cycles and then 1, with ch0 = `8'h11` and ch1 = `8'h08`. The sequences are 01→02→04→08→11 and 00→01→02→04→08.
2. Step and hold, in RUN: `en` = 1,0,0,1. ch0 must go 11→23, hold 23 for two cycles, then go to 47. `valid` stays 1 throughout.
3. Period, `WARMUP=0`, `en` held high: ch0 must return to `8'h01` after exactly 255 steps and never show `8'h00`.
4. Reload mid-run, with `load` and `en` both high: `dataOut` must equal the new seeds with no step applied, `valid` drops to 0 for 4 cycles, and warm-up replays identically.
5. Reset mid-warm-up, after 2 warm cycles: the state must restart, and `valid` rises exactly 4 cycles after the reset edge.
6. Bernoulli, `RNG_BERNOULLI_EN` defined: in RUN with ch0 = `8'h11` and ch1 = `8'h08`, `prob` = {`8'h05`, `8'h80`}, pulse `en`. One cycle later `sample` must equal `2'b01` and `sampleValid` must pulse for exactly 1 cycle. With the macro undefined, both outputs must stay 0.
